// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM sequencing ADDI/ADD/LW/SW over a shared req/ready bus.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             bus_ready,
  output logic             bus_req,
  output logic             bus_write,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alu_out_write,
  output logic             mdr_write,
  output logic [2:0]       alu_op,
  output logic             i_or_r,
  output logic             reg_write,
  output logic             load,
  output logic             halted,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, HALT = 3'd6
  } state_t;
  localparam logic [1:0] C_ADDI = 2'd0, C_ADD = 2'd1, C_LW = 2'd2, C_SW = 2'd3;
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  state_t           r_state;
  logic [1:0]       r_cls;
  logic [WW-1:0]    r_wait;
  logic             r_illegal;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_retired;
  logic [1:0]       w_cls;
  logic             w_legal;
  logic             w_bus;
  logic             w_timeout;
  logic             w_retire;
  logic             w_mem_op;
  assign w_cls = (op == 6'b000000) ? C_ADD : (op == 6'b100011) ? C_LW :
                 (op == 6'b101011) ? C_SW : C_ADDI;
  assign w_legal = (op == 6'b001000) || (op == 6'b000000 && funct == 6'b100000) ||
                   (op == 6'b100011) || (op == 6'b101011);
  assign w_bus = (r_state == FETCH) || (r_state == MEM);
  // A ready arriving on the final wait cycle wins over the timeout.
  assign w_timeout = (TIMEOUT != 0) && w_bus && !bus_ready && (r_wait == WW'(TIMEOUT - 1));
  assign w_retire = (r_state == WB) || (r_state == MEM && r_cls == C_SW && bus_ready);
  assign w_mem_op = (r_cls == C_LW) || (r_cls == C_SW);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cls     <= C_ADDI;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_wait <= (w_bus && !bus_ready) ? r_wait + 1'b1 : '0;
      if (w_retire) r_retired <= r_retired + 1'b1;
      case (r_state)
        IDLE: if (run) r_state <= FETCH;
        FETCH: begin
          if (bus_ready) r_state <= DECODE;
          else if (w_timeout) begin
            r_state   <= HALT;
            r_bus_err <= 1'b1;
          end
        end
        DECODE: begin
          r_cls <= w_cls;
          if (w_legal) r_state <= EXEC;
          else begin
            r_state   <= HALT;
            r_illegal <= 1'b1;
          end
        end
        EXEC: r_state <= w_mem_op ? MEM : WB;
        MEM: begin
          if (bus_ready) r_state <= (r_cls == C_SW) ? (run ? FETCH : IDLE) : WB;
          else if (w_timeout) begin
            r_state   <= HALT;
            r_bus_err <= 1'b1;
          end
        end
        WB: r_state <= run ? FETCH : IDLE;
        HALT: r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus_req       = w_bus;
  assign addr_sel      = (r_state == MEM);
  assign bus_write     = (r_state == MEM) && (r_cls == C_SW);
  assign ir_write      = (r_state == FETCH) && bus_ready;
  assign pc_write      = (r_state == FETCH) && bus_ready;
  assign alu_out_write = (r_state == EXEC);
  assign alu_op        = {2'b00, r_state == EXEC};
  assign i_or_r        = (r_state == EXEC || r_state == WB) && (r_cls == C_ADD);
  assign mdr_write     = (r_state == MEM) && (r_cls == C_LW) && bus_ready;
  assign reg_write     = (r_state == WB);
  assign load          = (r_state == WB) && (r_cls == C_LW);
  assign halted        = (r_state == HALT);
  assign illegal_op    = r_illegal;
  assign bus_err       = r_bus_err;
  assign state         = r_state;
  assign retired       = r_retired;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed plus randomized instruction streams checked against a per-instruction phase model.
module tb_multicycle_sequencer;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam logic [13:0] K_REQ = 14'h2000, K_WR = 14'h1000, K_AS = 14'h0800, K_IR = 14'h0400,
                          K_PC = 14'h0200, K_AW = 14'h0100, K_MD = 14'h0080, K_ALU = 14'h0010,
                          K_IOR = 14'h0008, K_RW = 14'h0004, K_LD = 14'h0002, K_HL = 14'h0001;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, bus_ready = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic bus_req, bus_write, addr_sel, ir_write, pc_write, alu_out_write, mdr_write;
  logic [2:0] alu_op;
  logic i_or_r, reg_write, load, halted, illegal_op, bus_err;
  logic [2:0] state;
  logic [CW-1:0] retired;
  int checks = 0, failures = 0, n_ret = 0;
  logic idle = 1'b1;
  logic ok;
  logic [13:0] w_ctl;

  multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .op(op), .funct(funct), .bus_ready(bus_ready),
    .bus_req(bus_req), .bus_write(bus_write), .addr_sel(addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .alu_out_write(alu_out_write), .mdr_write(mdr_write), .alu_op(alu_op),
    .i_or_r(i_or_r), .reg_write(reg_write), .load(load), .halted(halted),
    .illegal_op(illegal_op), .bus_err(bus_err), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;
  assign w_ctl = {bus_req, bus_write, addr_sel, ir_write, pc_write, alu_out_write, mdr_write,
                  alu_op, i_or_r, reg_write, load, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] es, input logic br, input logic [13:0] ev);
    bus_ready = br;
    @(negedge clk);
    chk("state", 32'(state), 32'(es));
    chk("controls", 32'(w_ctl), 32'(ev));
    @(posedge clk);
    #1;
  endtask

  task automatic bus_phase(input logic [2:0] es, input int w, input logic [13:0] ev,
                           input logic [13:0] ev_done, output logic done);
    for (int i = 0; i < w && i < TO; i++) cyc(es, 1'b0, ev);
    done = (w < TO);
    if (done) cyc(es, 1'b1, ev | ev_done);
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_controls", 32'(w_ctl), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_flags", 32'({illegal_op, bus_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_ret = 0;
    idle = 1'b1;
  endtask

  task automatic halt_check(input logic ill, input logic be);
    for (int i = 0; i < 3; i++) begin
      run = 1'($urandom);
      cyc(3'd6, 1'($urandom), K_HL);
    end
    chk("illegal_op", 32'(illegal_op), 32'(ill));
    chk("bus_err", 32'(bus_err), 32'(be));
    chk("halt_retired", 32'(retired), 32'(n_ret % (1 << CW)));
  endtask

  // kind: 0 ADDI, 1 ADD, 2 LW, 3 SW, 4 illegal; fw/mw are bus wait cycles in fetch/memory.
  task automatic instr(input int kind, input int fw, input int mw, input logic run_after,
                       output logic done);
    logic [13:0] ior;
    logic [5:0] f;
    ior = (kind == 1) ? K_IOR : 14'h0;
    f = 6'($urandom);
    if (kind == 4 && f == 6'b100000) f = 6'b100010;
    op = (kind == 0) ? 6'b001000 : (kind == 2) ? 6'b100011 : (kind == 3) ? 6'b101011 : 6'b000000;
    funct = (kind == 1) ? 6'b100000 : f;
    run = 1'b1;
    done = 1'b0;
    if (idle) cyc(3'd0, 1'($urandom), 14'h0);
    idle = 1'b0;
    bus_phase(3'd1, fw, K_REQ, K_IR | K_PC, done);
    if (!done) return;
    cyc(3'd2, 1'($urandom), 14'h0);
    if (kind == 4) begin
      done = 1'b0;
      return;
    end
    op = 6'($urandom);
    funct = 6'($urandom);
    run = run_after;
    cyc(3'd3, 1'($urandom), K_ALU | K_AW | ior);
    if (kind == 2 || kind == 3) begin
      bus_phase(3'd4, mw, K_REQ | K_AS | ((kind == 3) ? K_WR : 14'h0),
                (kind == 2) ? K_MD : 14'h0, done);
      if (!done) return;
    end
    if (kind != 3) cyc(3'd5, 1'($urandom), K_RW | ior | ((kind == 2) ? K_LD : 14'h0));
    n_ret++;
    chk("retired", 32'(retired), 32'(n_ret % (1 << CW)));
    idle = !run_after;
    done = 1'b1;
  endtask

  initial begin
    do_reset();
    instr(0, 0, 0, 1'b1, ok);
    instr(1, 0, 0, 1'b1, ok);
    instr(2, 0, 0, 1'b1, ok);
    instr(3, 0, 0, 1'b0, ok);
    run = 1'b0;
    cyc(3'd0, 1'b1, 14'h0);
    instr(2, 0, 3, 1'b1, ok);
    instr(1, 3, 0, 1'b0, ok);
    run = 1'b0;
    cyc(3'd0, 1'b0, 14'h0);
    for (int i = 0; i < 30; i++)
      instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom), ok);
    instr(4, 0, 0, 1'b1, ok);
    chk("illegal_no_retire", 32'(ok), 32'd0);
    halt_check(1'b1, 1'b0);
    do_reset();
    instr(0, 4, 0, 1'b1, ok);
    chk("fetch_timeout", 32'(ok), 32'd0);
    halt_check(1'b0, 1'b1);
    do_reset();
    instr(3, 1, 4, 1'b1, ok);
    chk("mem_timeout", 32'(ok), 32'd0);
    halt_check(1'b0, 1'b1);
    do_reset();
    op = 6'b100011;
    funct = '0;
    run = 1'b1;
    cyc(3'd0, 1'b0, 14'h0);
    cyc(3'd1, 1'b1, K_REQ | K_IR | K_PC);
    cyc(3'd2, 1'b0, 14'h0);
    cyc(3'd3, 1'b0, K_ALU | K_AW);
    cyc(3'd4, 1'b0, K_REQ | K_AS);
    do_reset();
    instr(0, 0, 0, 1'b0, ok);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the single-issue MIPS datapath. It sequences fetch, decode, execute, memory and writeback for ADDI, ADD, LW and SW over one shared instruction/data bus with a req/ready handshake.
- It drives the ALU op, operand select and register-file/bus enables that the datapath consumes.
- It halts on illegal opcodes and on bus timeouts, and counts retired instructions.

Parameters:
- TIMEOUT, 16: max cycles bus_req may wait for bus_ready before a bus error; 0 disables the timeout.
- CNT_W, 32: width of the retired counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary
- op  in  6  opcode from instruction register
- funct  in  6  funct field from instruction register
- bus_ready  in  1  bus completes current access this cycle
- bus_req  out  1  bus access request
- bus_write  out  1  1 = store, 0 = read
- addr_sel  out  1  0 = PC address, 1 = ALU-result address
- ir_write  out  1  latch instruction register
- pc_write  out  1  PC <= PC+4
- alu_out_write  out  1  latch ALU result register
- mdr_write  out  1  latch memory data register
- alu_op  out  3  ALU function; 1 = add, 0 = none
- i_or_r  out  1  1 = R-type (rt operand, rd dest), 0 = I-type (imm operand, rt dest)
- reg_write  out  1  register-file write enable
- load  out  1  writeback source: 1 = MDR, 0 = ALU result
- halted  out  1  FSM is in HALT
- illegal_op  out  1  sticky: halted on an undecodable instruction
- bus_err  out  1  sticky: halted on a bus timeout
- state  out  3  current state encoding, for debug
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low.
- Reset value: state=IDLE.
  - All outputs are 0, including retired, illegal_op and bus_err.
  - Reset mid-instruction aborts it immediately, with no pending writes.
- Encodings:
  - IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
  - ADDI op=001000; ADD op=000000 with funct=100000; LW op=100011; SW op=101011.
  - op=000000 with any other funct is illegal.
- Output timing:
  - Outputs are decoded combinationally from the state register and the registered instruction class.
  - ir_write, pc_write and mdr_write are additionally gated by bus_ready.
- Instruction class: sampled from op/funct only in DECODE and held in a register; later op/funct changes are ignored.
- IDLE: all controls 0. run=1 -> FETCH.
- FETCH:
  - Drives bus_req=1, addr_sel=0, bus_write=0.
  - On bus_ready: ir_write=1 and pc_write=1 for that cycle, then -> DECODE.
- DECODE:
  - Legal class -> EXEC.
  - Illegal -> HALT and set illegal_op.
- EXEC:
  - Drives alu_op=1, alu_out_write=1, and i_or_r=1 only for ADD.
  - ADD/ADDI -> WB; LW/SW -> MEM.
- MEM:
  - Drives bus_req=1, addr_sel=1, and bus_write=1 only for SW.
  - On bus_ready: LW asserts mdr_write=1 and goes -> WB. SW retires and goes -> FETCH if run=1, else -> IDLE.
- WB:
  - Drives reg_write=1, load=1 only for LW, and i_or_r as in EXEC.
  - Retires, then -> FETCH if run=1, else -> IDLE.
- HALT:
  - halted=1; all other controls 0.
  - Left only via reset; run is ignored.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle bus_ready=0.
  - When it reaches TIMEOUT with bus_ready still 0 -> HALT, set bus_err, and deassert bus_req the next cycle.
  - bus_ready in the same cycle as the timeout takes priority: the access completes.
- Handshake rules:
  - bus_req stays high and stable, with the same addr_sel/bus_write, until bus_ready.
  - bus_ready outside FETCH/MEM is ignored.
- run:
  - Sampled only at the IDLE exit and at retirement.
  - Dropping run mid-instruction completes that instruction.
- Latency with zero-wait bus (bus_ready=1 on the first request cycle):
  - ADD/ADDI: 4 cycles FETCH->WB.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Each bus wait cycle adds 1.
- retired:
  - Increments by 1 on the cycle leaving WB, or leaving MEM for SW.
  - Wraps from all-ones to 0.

Test Plan:
- Reset, run=1, zero-wait bus, ADDI -> FETCH,DECODE,EXEC,WB. reg_write=1, i_or_r=0, load=0 in cycle 4; retired=1.
- ADD (funct=100000), then LW, then SW, run held, zero-wait bus -> 4+5+4=13 cycles. LW's WB has load=1; SW's MEM has bus_write=1, addr_sel=1; retired=3.
- LW with bus_ready delayed 3 cycles in MEM -> bus_req/addr_sel/bus_write stable for 4 cycles, mdr_write pulses exactly once, LW total 8 cycles.
- op=000000, funct=100010 -> DECODE -> HALT: halted=1, illegal_op=1, reg_write never asserted. run toggling has no effect until rst_n pulses low.
- TIMEOUT=4, bus_ready held 0 in FETCH -> bus_req high 4 cycles, then HALT with bus_err=1.
  - Repeat with bus_ready=1 on the 4th wait cycle -> normal DECODE.
- Drop run during EXEC of ADD -> WB still writes, then IDLE with retired incremented.
  - Assert rst_n low mid-MEM -> all outputs 0 immediately, state=0.
